rf_write_sched: RTL and testbench

- Write-port scheduler for the 32x32 register file: owns the single write port (we3/wa3/wd3) and shares it between two writeback requesters (req0 = ALU writeback, req1 = load writeback).
- After reset, scrubs registers 1..31 to zero, then arbitrates round-robin with valid/ready handshakes.
- Sits between the pipeline writeback stages and regfile; regfile read ports are untouched.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_arb2.sv | 21 ++
 rtl/rf_write_sched.sv | 97 +++++++++
 tb/tb_rf_write_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    typedef enum logic {
        SCRUB,
        RUN
    } rf_sched_state_t;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the input that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_sched.sv
// Owns the regfile write port: zero-scrubs x1..x31 after reset, then shares the
// port between ALU writeback (req0) and load writeback (req1) round-robin.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              init_done
);

    localparam rf_sched_state_t RESET_STATE = SCRUB_EN ? SCRUB : RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_sched_state_t   state;
    rf_sched_state_t   state_next;
    logic [ADDR_W-1:0] cnt;
    logic              last_grant;
    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .enable     (state == RUN),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign win_addr   = grant[1] ? req1_addr : req0_addr;
    assign win_data   = grant[1] ? req1_data : req0_data;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == SCRUB && cnt == LAST_ADDR) begin
            state_next = RUN;
        end
    end

    // Scrub starts at x1 so x0 is never driven onto the port.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            cnt        <= ADDR_W'(1);
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            init_done  <= 1'b0;
        end else if (state == SCRUB) begin
            rf_we <= 1'b1;
            rf_wa <= cnt;
            rf_wd <= '0;
            cnt   <= cnt + ADDR_W'(1);
            if (cnt == LAST_ADDR) begin
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
            if (accept) begin
                // x0 writes complete the handshake but never reach the port.
                rf_we      <= (win_addr != '0);
                rf_wa      <= win_addr;
                rf_wd      <= win_data;
                last_grant <= grant[1];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched with a per-cycle reference model and literal spot checks.
module tb_rf_write_sched;

    logic        clock = 1'b0;
    logic        reset_b;
    logic        r0v, r1v;
    logic [4:0]  r0a, r1a;
    logic [31:0] r0d, r1d;
    logic        req0_ready, req1_ready, rf_we, init_done;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic        ns_r0v, ns_r1v;
    logic [4:0]  ns_r0a, ns_r1a;
    logic [31:0] ns_r0d, ns_r1d;
    logic        ns_ready0, ns_ready1, ns_we, ns_done;
    logic [4:0]  ns_wa;
    logic [31:0] ns_wd;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rf_write_sched #(.DATA_W(32), .ADDR_W(5), .SCRUB_EN(1'b1)) dut (
        .clock(clock), .reset_b(reset_b),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .init_done(init_done)
    );

    rf_write_sched #(.DATA_W(32), .ADDR_W(5), .SCRUB_EN(1'b0)) dut_ns (
        .clock(clock), .reset_b(reset_b),
        .req0_valid(ns_r0v), .req0_addr(ns_r0a), .req0_data(ns_r0d), .req0_ready(ns_ready0),
        .req1_valid(ns_r1v), .req1_addr(ns_r1a), .req1_data(ns_r1d), .req1_ready(ns_ready1),
        .rf_we(ns_we), .rf_wa(ns_wa), .rf_wd(ns_wd), .init_done(ns_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scrub walks x1..x31, then every accepted request shows
    // on the port one cycle later (x0 suppressed); ties go to the other requester.
    bit          m_scrub = 1'b1;
    int          m_next  = 1;
    int          m_prev  = 1;
    logic        e_we    = 1'b0;
    logic [4:0]  e_wa    = '0;
    logic [31:0] e_wd    = '0;
    logic        e_done  = 1'b0;

    function automatic int winner();
        if (m_scrub) return -1;
        if (r0v && r1v) return (m_prev == 0) ? 1 : 0;
        if (r0v) return 0;
        if (r1v) return 1;
        return -1;
    endfunction

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            m_scrub = 1'b1; m_next = 1; m_prev = 1;
            e_we = 1'b0; e_wa = '0; e_wd = '0; e_done = 1'b0;
        end else if (m_scrub) begin
            e_we = 1'b1;
            e_wa = 5'(m_next);
            e_wd = '0;
            if (m_next == 31) begin
                m_scrub = 1'b0;
                e_done  = 1'b1;
            end
            m_next++;
        end else begin
            int w;
            w = winner();
            e_done = 1'b1;
            if (w < 0) begin
                e_we = 1'b0;
            end else begin
                e_wa   = (w == 0) ? r0a : r1a;
                e_wd   = (w == 0) ? r0d : r1d;
                e_we   = (e_wa != 5'd0);
                m_prev = w;
            end
        end
    end

    always @(negedge clock) begin
        int w;
        w = winner();
        chk("m_ready0", req0_ready, (w == 0));
        chk("m_ready1", req1_ready, (w == 1));
        chk("m_we", rf_we, e_we);
        chk("m_done", init_done, e_done);
        if (e_we) begin
            chk("m_wa", rf_wa, e_wa);
            chk("m_wd", rf_wd, e_wd);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        reset_b = 1'b1;
        r0v = 0; r0a = '0; r0d = '0; r1v = 0; r1a = '0; r1d = '0;
        ns_r1v = 0; ns_r1a = '0; ns_r1d = '0;
        ns_r0v = 1; ns_r0a = 5'd30; ns_r0d = 32'h1234_5678;
        #2 reset_b = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_b = 1'b1;

        // Before the first edge after release.
        @(negedge clock);
        chk("ns_ready_first", ns_ready0, 1'b1);
        chk("ns_done_pre", ns_done, 1'b0);
        chk("scrub_we_pre", rf_we, 1'b0);
        @(posedge clock); #1 ns_r0v = 0;
        @(negedge clock);
        chk("scrub_wa1", rf_wa, 5'd1);
        chk("scrub_we1", rf_we, 1'b1);
        chk("ns_done", ns_done, 1'b1);
        chk("ns_we", ns_we, 1'b1);
        chk("ns_wa", ns_wa, 5'd30);
        chk("ns_wd", ns_wd, 32'h1234_5678);
        @(negedge clock);
        chk("ns_we_idle", ns_we, 1'b0);
        repeat (29) @(negedge clock);
        chk("scrub_wa31", rf_wa, 5'd31);
        chk("scrub_done", init_done, 1'b1);
        chk("scrub_ready0", req0_ready, 1'b0);

        // Continuous contention: grants alternate starting with req0.
        @(posedge clock); #1;
        r0v = 1; r0a = 5'd3; r0d = 32'hA; r1v = 1; r1a = 5'd7; r1d = 32'hB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) chk("idle_we", rf_we, 1'b0);
            else chk("cont_wa", rf_wa, (i % 2 == 1) ? 5'd3 : 5'd7);
            chk("cont_ready0", req0_ready, (i % 2 == 0));
            chk("cont_ready1", req1_ready, (i % 2 == 1));
            @(posedge clock); #1;
            if (i == 3) begin r0v = 0; r1v = 0; end
        end
        @(negedge clock);
        chk("cont_wa_last", rf_wa, 5'd7);

        // x0 write from req1, then a tie goes to req0.
        @(posedge clock); #1;
        r1v = 1; r1a = 5'd0; r1d = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("x0_ready1", req1_ready, 1'b1);
        @(posedge clock); #1;
        r0v = 1; r0a = 5'd9; r0d = 32'h99; r1a = 5'd4; r1d = 32'h44;
        @(negedge clock);
        chk("x0_we", rf_we, 1'b0);
        chk("tie_ready0", req0_ready, 1'b1);
        chk("tie_ready1", req1_ready, 1'b0);
        @(posedge clock); #1 r0v = 0;
        @(negedge clock);
        chk("tie_wa", rf_wa, 5'd9);
        chk("held_ready1", req1_ready, 1'b1);
        @(posedge clock); #1 r1v = 0;
        @(negedge clock);
        chk("held_wd", rf_wd, 32'h44);

        // Single req0 write.
        @(posedge clock); #1;
        r0v = 1; r0a = 5'd5; r0d = 32'h2B97_1485;
        @(negedge clock);
        chk("single_ready0", req0_ready, 1'b1);
        @(posedge clock); #1 r0v = 0;
        @(negedge clock);
        chk("single_we", rf_we, 1'b1);
        chk("single_wa", rf_wa, 5'd5);
        chk("single_wd", rf_wd, 32'h2B97_1485);
        @(negedge clock);
        chk("single_idle_we", rf_we, 1'b0);
        chk("single_hold_wa", rf_wa, 5'd5);

        // Reset mid-RUN, then again at scrub cycle 10.
        @(posedge clock); #1 reset_b = 1'b0;
        #1;
        chk("rst_run_done", init_done, 1'b0);
        chk("rst_run_we", rf_we, 1'b0);
        @(posedge clock); #1 reset_b = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("scrub10_wa", rf_wa, 5'd10);
        chk("scrub10_we", rf_we, 1'b1);
        reset_b = 1'b0;
        #1;
        chk("rst_scrub_we", rf_we, 1'b0);
        chk("rst_scrub_done", init_done, 1'b0);
        @(posedge clock); #1 reset_b = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("restart_wa1", rf_wa, 5'd1);
        repeat (30) @(negedge clock);
        chk("restart_wa31", rf_wa, 5'd31);
        chk("restart_done", init_done, 1'b1);
        @(negedge clock);
        chk("restart_idle_we", rf_we, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
